// File: rtl/memory_pkg.sv
// Shared types for memory_dp_clr: clear-sequencer states and byte parity helper.
// Even parity: the stored bit makes the total count of ones in byte+bit even.
package memory_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/mem_bank_be.sv
// Byte-lane RAM: one write port with per-lane enables, one read port with a registered output.
// Read data appears one cycle after re_i and holds until the next read; never stalls.
module mem_bank_be #(
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_LANES  = 4,
  parameter int LANE_W     = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          we_i,
  input  logic [ADDR_WIDTH-1:0]         waddr_i,
  input  logic [NUM_LANES-1:0]          wbe_i,
  input  logic [NUM_LANES*LANE_W-1:0]   wdat_i,
  input  logic                          re_i,
  input  logic [ADDR_WIDTH-1:0]         raddr_i,
  output logic [NUM_LANES*LANE_W-1:0]   rdat_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [NUM_LANES*LANE_W-1:0] mem_q [DEPTH];
  logic [NUM_LANES*LANE_W-1:0] rdat_q;

  // The array itself carries no reset; only the read register is flushed.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (wbe_i[i]) begin
          mem_q[waddr_i][i*LANE_W +: LANE_W] <= wdat_i[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rdat_q <= '0;
    end else if (re_i) begin
      rdat_q <= mem_q[raddr_i];
    end
  end

  assign rdat_o = rdat_q;

endmodule

// File: rtl/memory_dp_clr.sv
// Dual-port byte-enable RAM with self-clear sequencer; read latency 1+OUT_REG, no backpressure.
// Ports are ignored while busy (clear sweep). Define MEM_PARITY_EN for per-byte parity and par_err.
module memory_dp_clr
  import memory_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int OUT_REG    = 0,
  parameter int RDW_MODE   = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_req,
  output logic                    busy,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
`ifdef MEM_PARITY_EN
  output logic                    par_err,
`endif
  output logic                    rd_valid
);

  localparam int NB = DATA_WIDTH / 8;
`ifdef MEM_PARITY_EN
  localparam int LANE_W = 9;
`else
  localparam int LANE_W = 8;
`endif
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    init_q;

  // init_q forces a full clear on the first cycle after reset release.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      init_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      init_q  <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_req || init_q) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q == ST_CLEAR);

  logic rd_acc, wr_acc;
  assign rd_acc = rd_en && !busy;
  assign wr_acc = wr_en && !busy;

  logic                   bank_we;
  logic [ADDR_WIDTH-1:0]  bank_waddr;
  logic [NB-1:0]          bank_wbe;
  logic [NB*LANE_W-1:0]   bank_wdat;
  logic [NB*LANE_W-1:0]   bank_rdat;

  always_comb begin
    bank_we    = rst_n && wr_acc;
    bank_waddr = wr_addr;
    bank_wbe   = wr_be;
    bank_wdat  = '0;
    for (int i = 0; i < NB; i++) begin
`ifdef MEM_PARITY_EN
      bank_wdat[i*LANE_W +: LANE_W] = {byte_parity(wr_data[i*8 +: 8]), wr_data[i*8 +: 8]};
`else
      bank_wdat[i*LANE_W +: LANE_W] = wr_data[i*8 +: 8];
`endif
    end
    if (busy) begin
      bank_we    = rst_n;
      bank_waddr = cnt_q;
      bank_wbe   = '1;
      bank_wdat  = '0;
    end
  end

  mem_bank_be #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_LANES  (NB),
    .LANE_W     (LANE_W)
  ) u_bank (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .we_i    (bank_we),
    .waddr_i (bank_waddr),
    .wbe_i   (bank_wbe),
    .wdat_i  (bank_wdat),
    .re_i    (rd_acc),
    .raddr_i (rd_addr),
    .rdat_o  (bank_rdat)
  );

  // Bypass lanes are latched only on an accepted read so rd_data holds between reads.
  logic                  v1_q;
  logic [NB-1:0]         byp_be_q;
  logic [DATA_WIDTH-1:0] byp_dat_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q      <= 1'b0;
      byp_be_q  <= '0;
      byp_dat_q <= '0;
    end else begin
      v1_q <= rd_acc;
      if (rd_acc) begin
        byp_dat_q <= wr_data;
        byp_be_q  <= (RDW_MODE == 1 && wr_acc && wr_addr == rd_addr) ? wr_be : '0;
      end
    end
  end

  logic [DATA_WIDTH-1:0] s1_dat;
  always_comb begin
    s1_dat = '0;
    for (int i = 0; i < NB; i++) begin
      s1_dat[i*8 +: 8] = byp_be_q[i] ? byp_dat_q[i*8 +: 8] : bank_rdat[i*LANE_W +: 8];
    end
  end

`ifdef MEM_PARITY_EN
  // Bypassed lanes come from wr_data, not storage, so they are never checked.
  logic s1_perr;
  always_comb begin
    s1_perr = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (!byp_be_q[i] && (byte_parity(bank_rdat[i*LANE_W +: 8]) != bank_rdat[i*LANE_W + 8])) begin
        s1_perr = v1_q;
      end
    end
  end
`endif

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DATA_WIDTH-1:0] rd_data_q;
      logic                  rd_valid_q;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= v1_q;
          if (v1_q) rd_data_q <= s1_dat;
        end
      end
      assign rd_data  = rd_data_q;
      assign rd_valid = rd_valid_q;
`ifdef MEM_PARITY_EN
      logic par_err_q;
      always_ff @(posedge clk) begin
        if (!rst_n) par_err_q <= 1'b0;
        else        par_err_q <= s1_perr;
      end
      assign par_err = par_err_q;
`endif
    end else begin : g_noreg
      assign rd_data  = s1_dat;
      assign rd_valid = v1_q;
`ifdef MEM_PARITY_EN
      assign par_err  = s1_perr;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_memory_dp_clr.sv
// Directed bench for memory_dp_clr: reset clear, byte enables, read-during-write, clear ignore, reset abort.
// Parity scenario is compiled in only when MEM_PARITY_EN is defined.
module tb_memory_dp_clr;

  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int OREG  = 0;
  localparam int RDW   = 1;
  localparam int LAT   = 1 + OREG;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr_req;
  logic          busy;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW/8-1:0] wr_be;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
`ifdef MEM_PARITY_EN
  logic          par_err;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  memory_dp_clr #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .OUT_REG    (OREG),
    .RDW_MODE   (RDW)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .busy     (busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_be    (wr_be),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
`ifdef MEM_PARITY_EN
    .par_err  (par_err),
`endif
    .rd_valid (rd_valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clr_req = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_be   = '0;
    wr_data = '0;
    rd_en   = 1'b0;
    rd_addr = '0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [3:0] be, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_be   = be;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
    wr_be   = '0;
  endtask

  // Issues one read and returns the data at the first rd_valid and the latency (-1 if none).
  task automatic do_read(input logic [AW-1:0] a, output logic [31:0] d, output int lat);
    rd_en   = 1'b1;
    rd_addr = a;
    tick();
    rd_en = 1'b0;
    lat   = 1;
    while (rd_valid !== 1'b1 && lat < 8) begin
      tick();
      lat++;
    end
    d = rd_data;
    if (rd_valid !== 1'b1) lat = -1;
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
    checks++;
    if (rd_data !== 32'h0) begin failures++; $display("FAIL reset_rd_data: got %h expected 00000000", rd_data); end
`ifdef MEM_PARITY_EN
    checks++;
    if (par_err !== 1'b0) begin failures++; $display("FAIL reset_par_err: got %b expected 0", par_err); end
`endif
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL release_busy: got %b expected 1", busy); end
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      n++;
      tick();
    end
    checks++;
    if (n != DEPTH) begin failures++; $display("FAIL release_clear_len: got %0d cycles expected %0d", n, DEPTH); end
  endtask

  task automatic test_clear_readback(input string tag);
    for (int i = 0; i < DEPTH + LAT - 1; i++) begin
      rd_en   = (i < DEPTH);
      rd_addr = i[AW-1:0];
      tick();
      if (i >= LAT - 1) begin
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 32'h0) begin
          failures++;
          $display("FAIL %s_addr%0d: got valid=%b data=%h expected valid=1 data=00000000",
                   tag, i - LAT + 1, rd_valid, rd_data);
        end
      end
    end
    rd_en = 1'b0;
    tick();
    checks++;
    if (rd_valid !== 1'b0) begin failures++; $display("FAIL %s_valid_end: got %b expected 0", tag, rd_valid); end
  endtask

  task automatic test_byte_enable();
    logic [31:0] d;
    int lat;
    do_write(10'd5, 4'hF, 32'h11223344);
    do_write(10'd5, 4'b0101, 32'hDEADBEEF);
    do_read(10'd5, d, lat);
    checks++;
    if (d !== 32'h11AD33EF) begin failures++; $display("FAIL be_merge: got %h expected 11ad33ef", d); end
    checks++;
    if (lat != LAT) begin failures++; $display("FAIL be_latency: got %0d expected %0d", lat, LAT); end
    tick();
    checks++;
    if (rd_valid !== 1'b0) begin failures++; $display("FAIL be_valid_pulse: got %b expected 0", rd_valid); end
    do_write(10'd5, 4'h0, 32'hFFFFFFFF);
    do_read(10'd5, d, lat);
    checks++;
    if (d !== 32'h11AD33EF) begin failures++; $display("FAIL be_zero: got %h expected 11ad33ef", d); end
    // Independent ports in one cycle, different addresses.
    wr_en = 1'b1; wr_addr = 10'd9; wr_be = 4'hF; wr_data = 32'h01020304;
    rd_en = 1'b1; rd_addr = 10'd5;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    repeat (LAT - 1) tick();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 32'h11AD33EF) begin
      failures++; $display("FAIL dual_port_rd: got valid=%b data=%h expected valid=1 data=11ad33ef", rd_valid, rd_data);
    end
    do_read(10'd9, d, lat);
    checks++;
    if (d !== 32'h01020304) begin failures++; $display("FAIL dual_port_wr: got %h expected 01020304", d); end
    repeat (3) tick();
    checks++;
    if (rd_data !== 32'h01020304) begin failures++; $display("FAIL rd_data_hold: got %h expected 01020304", rd_data); end
  endtask

  task automatic test_rdw();
    logic [31:0] d;
    logic [31:0] exp_d;
    int lat;
    do_write(10'd7, 4'hF, 32'h55555555);
    wr_en = 1'b1; wr_addr = 10'd7; wr_be = 4'b1100; wr_data = 32'hAAAAAAAA;
    rd_en = 1'b1; rd_addr = 10'd7;
    tick();
    wr_en = 1'b0; rd_en = 1'b0; wr_be = '0;
    lat = 1;
    while (rd_valid !== 1'b1 && lat < 8) begin tick(); lat++; end
    exp_d = (RDW == 1) ? 32'hAAAA5555 : 32'h55555555;
    checks++;
    if (rd_data !== exp_d || lat != LAT) begin
      failures++; $display("FAIL rdw_same_addr: got %h lat=%0d expected %h lat=%0d", rd_data, lat, exp_d, LAT);
    end
    do_read(10'd7, d, lat);
    checks++;
    if (d !== 32'hAAAA5555) begin failures++; $display("FAIL rdw_after: got %h expected aaaa5555", d); end
    do_read(10'd5, d, lat);
    checks++;
    if (d !== 32'h11AD33EF) begin failures++; $display("FAIL rdw_no_linger: got %h expected 11ad33ef", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q [4];
    for (int i = 0; i < 4; i++) begin
      exp_q[i] = 32'hA0000000 + i * 32'h01010101;
      do_write(10'd40 + i[AW-1:0], 4'hF, exp_q[i]);
    end
    for (int i = 0; i < 4 + LAT - 1; i++) begin
      rd_en   = (i < 4);
      rd_addr = 10'd40 + i[AW-1:0];
      tick();
      if (i >= LAT - 1) begin
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== exp_q[i-LAT+1]) begin
          failures++;
          $display("FAIL b2b_%0d: got valid=%b data=%h expected valid=1 data=%h",
                   i - LAT + 1, rd_valid, rd_data, exp_q[i-LAT+1]);
        end
      end
    end
    rd_en = 1'b0;
    tick();
    checks++;
    if (rd_valid !== 1'b0) begin failures++; $display("FAIL b2b_end: got %b expected 0", rd_valid); end
  endtask

  task automatic test_clear_ignore();
    int n;
    int pulses;
    bit got;
    do_write(10'd2, 4'hF, 32'hCAFEF00D);
    do_write(10'd1023, 4'hF, 32'h12345678);
    clr_req = 1'b1; rd_en = 1'b1; rd_addr = 10'd2;
    tick();
    clr_req = 1'b0; rd_en = 1'b0;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL clr_busy: got %b expected 1", busy); end
    n = 1; pulses = 0; got = 1'b0;
    while (busy === 1'b1 && n < 2000) begin
      if (rd_valid === 1'b1) begin
        if (n == LAT && !got) begin
          got = 1'b1;
          checks++;
          if (rd_data !== 32'hCAFEF00D) begin
            failures++; $display("FAIL clr_inflight_data: got %h expected cafef00d", rd_data);
          end
        end else begin
          pulses++;
        end
      end
      wr_en   = (n >= 10 && n < 900);
      wr_addr = 10'd2;
      wr_be   = 4'hF;
      wr_data = 32'hFFFFFFFF;
      rd_en   = (n >= 5 && n < 900);
      rd_addr = 10'd2;
      clr_req = (n == 50 || n == 600);
      tick();
      n++;
    end
    if (rd_valid === 1'b1) pulses++;
    idle_inputs();
    checks++;
    if (!got) begin failures++; $display("FAIL clr_inflight_valid: got none expected 1"); end
    checks++;
    if (pulses != 0) begin failures++; $display("FAIL clr_rd_ignored: got %0d pulses expected 0", pulses); end
    checks++;
    if (n - 1 != DEPTH) begin failures++; $display("FAIL clr_len: got %0d expected %0d", n - 1, DEPTH); end
    test_clear_readback("clr_zero");
  endtask

  task automatic test_reset_midclear();
    logic [31:0] d;
    int lat;
    int n;
    do_write(10'd800, 4'hF, 32'h0F0F0F0F);
    do_write(10'd100, 4'hF, 32'h0BADCAFE);
    do_read(10'd100, d, lat);
    checks++;
    if (d !== 32'h0BADCAFE) begin failures++; $display("FAIL abort_pre_read: got %h expected 0badcafe", d); end
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    n = 1;
    while (busy === 1'b1 && n < 300) begin tick(); n++; end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL abort_busy_300: got %b expected 1", busy); end
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 32'h0) begin
      failures++;
      $display("FAIL abort_reset_outs: got busy=%b valid=%b data=%h expected 0 0 00000000", busy, rd_valid, rd_data);
    end
    rst_n = 1'b1;
    tick();
    n = 0;
    while (busy === 1'b1 && n < 2000) begin n++; tick(); end
    checks++;
    if (n != DEPTH) begin failures++; $display("FAIL abort_restart_len: got %0d expected %0d", n, DEPTH); end
    test_clear_readback("abort_zero");
  endtask

`ifdef MEM_PARITY_EN
  task automatic test_parity();
    logic [31:0] d;
    int lat;
    do_write(10'd3, 4'hF, 32'h12345678);
    do_write(10'd4, 4'hF, 32'h87654321);
    u_dut.u_bank.mem_q[3][8] = ~u_dut.u_bank.mem_q[3][8];
    do_read(10'd3, d, lat);
    checks++;
    if (par_err !== 1'b1 || lat != LAT) begin
      failures++; $display("FAIL par_flip: got par_err=%b lat=%0d expected 1 lat=%0d", par_err, lat, LAT);
    end
    do_read(10'd4, d, lat);
    checks++;
    if (par_err !== 1'b0 || d !== 32'h87654321) begin
      failures++; $display("FAIL par_clean: got par_err=%b data=%h expected 0 87654321", par_err, d);
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_clear_readback("init_zero");
    test_byte_enable();
    test_rdw();
    test_back_to_back();
    test_clear_ignore();
    test_reset_midclear();
`ifdef MEM_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
